// File: rtl/gcd_unit_param.sv
// Subtraction-based GCD engine with valid/ready handshakes on both sides.
// Operand registers, comparator, subtractors and the controller share one block.
module gcd_unit_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic accept;
    logic release_res;
    logic any_zero;
    logic equal;
    logic a_gt_b;
    logic cnt_max;

    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;
    assign any_zero    = (a_reg == '0) || (b_reg == '0);
    assign equal       = (a_reg == b_reg);
    assign a_gt_b      = (a_reg > b_reg);
    assign cnt_max     = &iter_count;

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (any_zero || equal) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (release_res) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load operands, subtract smaller from larger, capture result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            gcd_out    <= '0;
            iter_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= a_in;
                        b_reg      <= b_in;
                        iter_count <= '0;
                    end
                end
                COMPUTE: begin
                    if (any_zero) begin
                        gcd_out <= a_reg | b_reg;
                    end else if (equal) begin
                        gcd_out <= a_reg;
                    end else if (a_gt_b) begin
                        a_reg <= a_reg - b_reg;
                        if (!cnt_max) begin
                            iter_count <= iter_count + CNT_W'(1);
                        end
                    end else begin
                        b_reg <= b_reg - a_reg;
                        if (!cnt_max) begin
                            iter_count <= iter_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_unit_param.sv
// Bench for gcd_unit_param: directed vectors plus an Euclid-based reference
// model checked every cycle against a 16-bit and an 8-bit-counter instance.
module tb_gcd_unit_param;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready8;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_valid8;
    logic        out_ready;
    logic [15:0] gcd_out;
    logic [15:0] gcd_out8;
    logic [15:0] iter_count;
    logic [7:0]  iter_count8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_edge = 0;
    bit rnd_en = 0;

    // monitor model state
    bit     busy = 0;
    int     m_acc = 0;
    longint m_steps = 0;
    longint m_gcd = 0;
    int     n_acc = 0;
    int     n_done = 0;

    gcd_unit_param #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .gcd_out(gcd_out), .iter_count(iter_count)
    );

    gcd_unit_param #(.WIDTH(16), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid8), .out_ready(out_ready),
        .gcd_out(gcd_out8), .iter_count(iter_count8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Reference: Euclid by division. Subtraction steps equal the sum of
    // quotients minus the final one that ends on equality.
    function automatic longint ref_gcd(input longint a, input longint b);
        longint x = a;
        longint y = b;
        longint t;
        if (a == 0 || b == 0) return a | b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic longint ref_steps(input longint a, input longint b);
        longint x = a;
        longint y = b;
        longint s = 0;
        longint t;
        if (a == 0 || b == 0) return 0;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return s - 1;
    endfunction

    // Cycle-by-cycle compare against the reference model.
    always @(negedge clk) begin
        bit exp_ov;
        if (rst) begin
            busy = 0;
        end else begin
            chk("in_ready", in_ready, !busy);
            chk("in_ready8", in_ready8, !busy);
            exp_ov = busy && (cyc >= m_acc + m_steps + 1);
            chk("out_valid", out_valid, exp_ov);
            chk("out_valid8", out_valid8, exp_ov);
            if (exp_ov) begin
                chk("gcd_out", gcd_out, m_gcd);
                chk("iter_count", iter_count, m_steps);
                chk("gcd_out8", gcd_out8, m_gcd);
                chk("iter_count8", iter_count8, (m_steps > 255) ? 255 : m_steps);
                if (out_ready) begin
                    busy = 0;
                    n_done++;
                end
            end else if (!busy && in_valid) begin
                busy = 1;
                m_acc = cyc + 1;
                m_gcd = ref_gcd(a_in, b_in);
                m_steps = ref_steps(a_in, b_in);
                n_acc++;
            end
        end
    end

    // Random back-pressure during the stress phase.
    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bit got = 0;
        a_in = a;
        b_in = b;
        in_valid = 1;
        for (int i = 0; i < 70000 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
        end
        if (!got) begin
            $display("FAIL accept_timeout: got 0 expected 1");
            errors++;
            checks++;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        acc_edge = cyc;
    endtask

    task automatic wait_valid(output int lat);
        bit got = 0;
        for (int i = 0; i < 70000 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) begin
            $display("FAIL result_timeout: got 0 expected 1");
            errors++;
            checks++;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "result timeout");
        end
        lat = cyc - acc_edge;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b,
                            input int eg, input int en, input int en8,
                            input int elat);
        int lat;
        send(a, b);
        wait_valid(lat);
        chk("dir_gcd", gcd_out, eg);
        chk("dir_iter", iter_count, en);
        chk("dir_iter8", iter_count8, en8);
        chk("dir_latency", lat, elat);
        @(posedge clk);
        #1;
        chk("dir_in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic [15:0] ta [4];
        logic [15:0] tb [4];
        int          tg [4];
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;

        rst = 1;
        in_valid = 0;
        a_in = 0;
        b_in = 0;
        out_ready = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_gcd", gcd_out, 0);
        chk("rst_iter", iter_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // T1
        directed(16'd12, 16'd8, 4, 2, 2, 3);

        // T2
        ta = '{16'd7, 16'd0, 16'd0, 16'd9};
        tb = '{16'd0, 16'd9, 16'd0, 16'd9};
        tg = '{7, 9, 0, 9};
        for (int i = 0; i < 4; i++) begin
            directed(ta[i], tb[i], tg[i], 0, 0, 1);
        end

        // T3
        directed(16'd65535, 16'd1, 1, 65534, 255, 65535);

        // T4: hold under back-pressure, extra operands ignored
        out_ready = 0;
        send(16'd48, 16'd18);
        wait_valid(lat);
        chk("t4_latency", lat, 5);
        a_in = 16'd99;
        b_in = 16'd33;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_gcd", gcd_out, 6);
            chk("t4_hold_iter", iter_count, 4);
            chk("t4_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("t4_in_ready_after", in_ready, 1);

        // T5: reset mid-computation
        send(16'd1071, 16'd462);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("t5_rst_gcd", gcd_out, 0);
        chk("t5_rst_iter", iter_count, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_iter8", iter_count8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        directed(16'd35, 16'd14, 7, 3, 3, 4);

        // T6: back-to-back random pairs with random back-pressure
        rnd_en = 1;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(1, 65535));
            rb = 16'($urandom_range(1, 65535));
            for (int k = 0; k < 1000 && ref_steps(ra, rb) > 150; k++) begin
                ra = 16'($urandom_range(1, 65535));
                rb = 16'($urandom_range(1, 65535));
            end
            if (ref_steps(ra, rb) > 150) rb = ra;
            if (i % 50 == 7) rb = 0;
            if (i % 37 == 3) ra = rb;
            send(ra, rb);
        end
        for (int i = 0; i < 2000 && n_done != n_acc; i++) @(posedge clk);
        rnd_en = 0;
        #2;
        out_ready = 1;
        repeat (2) @(posedge clk);
        chk("accepted_total", n_acc, 209);
        chk("completed_total", n_done, 208);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
